stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter DIV_MAX_CYCLES, default 40, max cycles awaited for divider result before timeout (range 2..63).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-low.
- stallreq_from_id  in  1  ID hazard stall request (level).
- stallreq_from_ex  in  1  EX generic stall request (level).
- ex_mc_kind  in  2  EX multi-cycle op: 00 none, 01 madd/msub, 10 div, 11 reserved (treated as none).
- div_ready_i  in  1  divider result valid.
- flush  in  1  abort in-flight multi-cycle op.
- stall  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = Stop.
- cnt_o  out  2  multi-cycle phase to EX/EX-MEM cnt path.
- div_start_o  out  1  divider start.
- div_annul_o  out  1  divider cancel pulse.
- div_timeout_o  out  1  sticky divider timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, MADD2, DIV_WAIT; reset state IDLE.
REQ-004 IDLE, ex_mc_kind=01: SHALL drive cnt_o=00 and stall ex-request pattern this cycle; next state MADD2.
REQ-005 MADD2: SHALL drive cnt_o=01, release internal stall request; next state IDLE unconditionally.
REQ-006 IDLE, ex_mc_kind=10: SHALL assert div_start_o (combinational, same cycle), assert internal stall request; next state DIV_WAIT; wait counter cleared to 0.
REQ-007 DIV_WAIT: SHALL hold div_start_o=1 and internal stall request while div_ready_i=0; wait counter increments per cycle.
REQ-008 DIV_WAIT with div_ready_i=1: SHALL drop div_start_o and internal stall request the same cycle; next state IDLE.
REQ-009 DIV_WAIT, wait counter = DIV_MAX_CYCLES-1 and div_ready_i=0: SHALL pulse div_annul_o one cycle, set div_timeout_o, go IDLE; stall released next cycle.
REQ-010 div_timeout_o SHALL remain set until reset; it does not block further operations.
REQ-011 ex_mc_kind SHALL be ignored outside IDLE.
REQ-012 flush=1 in MADD2 or DIV_WAIT: SHALL go IDLE next cycle; in DIV_WAIT also pulse div_annul_o that cycle and drop div_start_o; flush overrides div_ready_i and timeout (timeout flag not set).
REQ-013 flush=1 in IDLE: SHALL not start a new op that cycle.
REQ-014 stall encoding, priority high to low: internal request or stallreq_from_ex -> 6'b001111; stallreq_from_id -> 6'b000111; else 6'b000000.
REQ-015 stall and cnt_o SHALL be combinational from state and inputs (zero latency); state, counter, flag registered.
REQ-016 cnt_o SHALL be 00 in IDLE and DIV_WAIT.

Reset
REQ-017 rst=0 at a clock edge: SHALL force IDLE, wait counter 0, div_timeout_o 0; while rst=0 all outputs SHALL be 0 regardless of inputs.
REQ-018 Reset mid-operation SHALL abandon the op without div_annul_o pulse.

Configuration
REQ-019 With STALL_CTRL_PERF_EN defined: SHALL add outputs perf_stall_cyc (32) counting cycles with stall[0]=1 and perf_div_cyc (32) counting DIV_WAIT cycles, both saturating at all-ones, cleared by reset.
REQ-020 Without STALL_CTRL_PERF_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-021 Stall patterns, Stop/NoStop, ex_mc_kind codes and state encodings SHALL live in the shared defines file.
REQ-022 Saturating perf counter SHALL be a sub-module sat_cnt32, instantiated twice only under STALL_CTRL_PERF_EN.

Verification
REQ-023 Bench SHALL cover:
- stallreq_from_id=1 and stallreq_from_ex=1 same cycle -> stall=001111.
- ex_mc_kind=01 one cycle -> cycle0 stall=001111 cnt_o=00; cycle1 stall=000000 cnt_o=01; cycle2 IDLE.
- ex_mc_kind=10, div_ready_i high after 5 cycles -> div_start_o and stall=001111 for 5 cycles, both 0 on ready cycle.
- DIV_MAX_CYCLES=4, div_ready_i never -> div_annul_o pulse at 4th wait cycle, div_timeout_o=1 sticky, stall=000000 next cycle.
- flush on 2nd DIV_WAIT cycle with div_ready_i=1 -> div_annul_o pulse, IDLE, div_timeout_o stays 0.
- rst=0 during DIV_WAIT -> all outputs 0, IDLE; with STALL_CTRL_PERF_EN, perf_stall_cyc=0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for stall_ctrl: stall patterns, Stop/NoStop levels,
// multi-cycle op codes and FSM state encoding.
package stall_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit order is [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
  localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_NONE = '0;

  localparam logic [1:0] CNT_FIRST  = 2'b00;
  localparam logic [1:0] CNT_SECOND = 2'b01;

  typedef enum logic [1:0] {
    MC_NONE = 2'b00,
    MC_MADD = 2'b01,
    MC_DIV  = 2'b10,
    MC_RSVD = 2'b11
  } mc_kind_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MADD2    = 2'b01,
    S_DIV_WAIT = 2'b10
  } state_e;

  function automatic logic [5:0] stall_pattern(input logic req_ex, input logic req_id);
    if (req_ex)      return STALL_EX;
    else if (req_id) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Pipeline <-> stall controller handshake bundle; master is the pipeline
// side raising requests, slave is the controller answering with stalls.
interface stall_ctrl_if;
  logic       stallreq_from_id;
  logic       stallreq_from_ex;
  logic [1:0] ex_mc_kind;
  logic       div_ready_i;
  logic       flush;
  logic [5:0] stall;
  logic [1:0] cnt_o;
  logic       div_start_o;
  logic       div_annul_o;
  logic       div_timeout_o;

  modport master (
    output stallreq_from_id, stallreq_from_ex, ex_mc_kind, div_ready_i, flush,
    input  stall, cnt_o, div_start_o, div_annul_o, div_timeout_o
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, ex_mc_kind, div_ready_i, flush,
    output stall, cnt_o, div_start_o, div_annul_o, div_timeout_o
  );
endinterface

// File: rtl/stall_ctrl_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones; synchronous active-low reset.
module sat_cnt32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller with madd/msub and divider sequencing.
// Optional perf counters are enabled by defining STALL_CTRL_PERF_EN.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [1:0]  ex_mc_kind,
  input  logic        div_ready_i,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic [1:0]  cnt_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_timeout_o
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_div_cyc
`endif
);

  localparam logic [5:0] WAIT_LAST = 6'(DIV_MAX_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic       tout_q, tout_d;

  logic       mc_req;
  logic [1:0] cnt_raw;
  logic       start_raw;
  logic       annul_raw;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tout_d    = tout_q;
    mc_req    = 1'b0;
    cnt_raw   = CNT_FIRST;
    start_raw = 1'b0;
    annul_raw = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!flush) begin
          unique case (mc_kind_e'(ex_mc_kind))
            MC_MADD: begin
              mc_req  = 1'b1;
              state_d = S_MADD2;
            end
            MC_DIV: begin
              mc_req    = 1'b1;
              start_raw = 1'b1;
              wcnt_d    = '0;
              state_d   = S_DIV_WAIT;
            end
            default: ;
          endcase
        end
      end

      S_MADD2: begin
        cnt_raw = CNT_SECOND;
        state_d = S_IDLE;
      end

      S_DIV_WAIT: begin
        // Flush wins over a same-cycle result or timeout.
        if (flush) begin
          annul_raw = 1'b1;
          state_d   = S_IDLE;
        end else if (div_ready_i) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          mc_req    = 1'b1;
          start_raw = 1'b1;
          annul_raw = 1'b1;
          tout_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          mc_req    = 1'b1;
          start_raw = 1'b1;
          wcnt_d    = wcnt_q + 6'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tout_q  <= tout_d;
    end
  end

  // Reset held low silences every output, including the sticky flag.
  assign stall         = rst ? stall_pattern(mc_req | stallreq_from_ex, stallreq_from_id) : STALL_NONE;
  assign cnt_o         = rst ? cnt_raw   : CNT_FIRST;
  assign div_start_o   = rst & start_raw;
  assign div_annul_o   = rst & annul_raw;
  assign div_timeout_o = rst & tout_q;

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cyc, div_cyc;

  sat_cnt32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (stall[0]),
    .cnt_o (stall_cyc)
  );

  sat_cnt32 u_div_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (state_q == S_DIV_WAIT),
    .cnt_o (div_cyc)
  );

  assign perf_stall_cyc = rst ? stall_cyc : '0;
  assign perf_div_cyc   = rst ? div_cyc   : '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed vector table, timeout sequence
// and randomized traffic against a cycle-level reference model.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       id;
    logic       ex;
    logic [1:0] kind;
    logic       ready;
    logic       flush;
  } in_t;

  typedef struct packed {
    logic [5:0] stall;
    logic [1:0] cnt;
    logic       start;
    logic       annul;
    logic       tout;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  // Model view: what op is pending, how many wait cycles have passed, flag.
  typedef struct {
    int phase;   // 0 nothing pending, 1 madd second beat due, 2 awaiting divider
    int waited;
    bit tout;
  } m_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stall_ctrl_if bus_a ();
  stall_ctrl_if bus_t ();

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_a_stall, perf_a_div, perf_t_stall, perf_t_div;
`endif

  stall_ctrl #(.DIV_MAX_CYCLES(40)) dut_a (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (bus_a.stallreq_from_id),
    .stallreq_from_ex (bus_a.stallreq_from_ex),
    .ex_mc_kind       (bus_a.ex_mc_kind),
    .div_ready_i      (bus_a.div_ready_i),
    .flush            (bus_a.flush),
    .stall            (bus_a.stall),
    .cnt_o            (bus_a.cnt_o),
    .div_start_o      (bus_a.div_start_o),
    .div_annul_o      (bus_a.div_annul_o),
    .div_timeout_o    (bus_a.div_timeout_o)
`ifdef STALL_CTRL_PERF_EN
    ,
    .perf_stall_cyc   (perf_a_stall),
    .perf_div_cyc     (perf_a_div)
`endif
  );

  stall_ctrl #(.DIV_MAX_CYCLES(4)) dut_t (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (bus_t.stallreq_from_id),
    .stallreq_from_ex (bus_t.stallreq_from_ex),
    .ex_mc_kind       (bus_t.ex_mc_kind),
    .div_ready_i      (bus_t.div_ready_i),
    .flush            (bus_t.flush),
    .stall            (bus_t.stall),
    .cnt_o            (bus_t.cnt_o),
    .div_start_o      (bus_t.div_start_o),
    .div_annul_o      (bus_t.div_annul_o),
    .div_timeout_o    (bus_t.div_timeout_o)
`ifdef STALL_CTRL_PERF_EN
    ,
    .perf_stall_cyc   (perf_t_stall),
    .perf_div_cyc     (perf_t_div)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  m_t ma, mt;

  function automatic in_t mi(logic r, logic id, logic ex, logic [1:0] k, logic rdy, logic fl);
    return '{rst: r, id: id, ex: ex, kind: k, ready: rdy, flush: fl};
  endfunction

  function automatic out_t mo(logic [5:0] s, logic [1:0] c, logic st, logic an, logic to);
    return '{stall: s, cnt: c, start: st, annul: an, tout: to};
  endfunction

  function automatic out_t get_a();
    return {bus_a.stall, bus_a.cnt_o, bus_a.div_start_o, bus_a.div_annul_o, bus_a.div_timeout_o};
  endfunction

  function automatic out_t get_t();
    return {bus_t.stall, bus_t.cnt_o, bus_t.div_start_o, bus_t.div_annul_o, bus_t.div_timeout_o};
  endfunction

  // Reference behaviour for one clock cycle: outputs now, model state after the edge.
  function automatic void model_eval(input m_t s, input in_t i, input int maxc,
                                     output out_t o, output m_t n);
    bit busy = 0;
    n = s;
    o = '0;
    if (!i.rst) begin
      n = '{phase: 0, waited: 0, tout: 0};
      return;
    end
    case (s.phase)
      0: if (!i.flush) begin
        if (i.kind == 2'd1) begin
          busy = 1; n.phase = 1;
        end else if (i.kind == 2'd2) begin
          busy = 1; o.start = 1; n.phase = 2; n.waited = 0;
        end
      end
      1: begin
        o.cnt = 2'd1; n.phase = 0;
      end
      default: begin
        if (i.flush) begin
          o.annul = 1; n.phase = 0;
        end else if (i.ready) begin
          n.phase = 0;
        end else if (s.waited + 1 == maxc) begin
          busy = 1; o.start = 1; o.annul = 1; n.tout = 1; n.phase = 0;
        end else begin
          busy = 1; o.start = 1; n.waited = s.waited + 1;
        end
      end
    endcase
    o.stall = (busy || i.ex) ? 6'b001111 : (i.id ? 6'b000111 : 6'b000000);
    o.tout  = s.tout;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got stall=%b cnt=%b start=%b annul=%b tout=%b, expected stall=%b cnt=%b start=%b annul=%b tout=%b",
               name, got.stall, got.cnt, got.start, got.annul, got.tout,
               exp.stall, exp.cnt, exp.start, exp.annul, exp.tout);
    end
  endtask

  task automatic drive(input in_t i);
    rst                    = i.rst;
    bus_a.stallreq_from_id = i.id;
    bus_a.stallreq_from_ex = i.ex;
    bus_a.ex_mc_kind       = i.kind;
    bus_a.div_ready_i      = i.ready;
    bus_a.flush            = i.flush;
    bus_t.stallreq_from_id = i.id;
    bus_t.stallreq_from_ex = i.ex;
    bus_t.ex_mc_kind       = i.kind;
    bus_t.div_ready_i      = i.ready;
    bus_t.flush            = i.flush;
  endtask

  // Apply inputs mid-cycle, compare both DUTs against the model, advance the model.
  task automatic step(input in_t i, input string name);
    out_t ea, et;
    m_t   na, nt;
    @(negedge clk);
    drive(i);
    #1;
    model_eval(ma, i, 40, ea, na);
    model_eval(mt, i, 4, et, nt);
    check({name, "/a"}, get_a(), ea);
    check({name, "/t"}, get_t(), et);
    ma = na;
    mt = nt;
  endtask

  vec_t tbl[25];

  initial begin
    ma = '{phase: 0, waited: 0, tout: 0};
    mt = '{phase: 0, waited: 0, tout: 0};
    drive(mi(0, 0, 0, 2'd0, 0, 0));

    //                r  id ex kind   rdy fl        stall       cnt  st an to
    tbl[0]  = '{mi(0, 1, 1, 2'd2, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[1]  = '{mi(1, 1, 1, 2'd0, 0, 0), mo(6'b001111, 2'd0, 0, 0, 0)};
    tbl[2]  = '{mi(1, 1, 0, 2'd0, 0, 0), mo(6'b000111, 2'd0, 0, 0, 0)};
    tbl[3]  = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[4]  = '{mi(1, 0, 0, 2'd1, 0, 0), mo(6'b001111, 2'd0, 0, 0, 0)};
    tbl[5]  = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd1, 0, 0, 0)};
    tbl[6]  = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[7]  = '{mi(1, 0, 0, 2'd3, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[8]  = '{mi(1, 0, 0, 2'd1, 0, 1), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[9]  = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[10] = '{mi(1, 0, 0, 2'd2, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[11] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[12] = '{mi(1, 0, 0, 2'd1, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[13] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[14] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[15] = '{mi(1, 0, 0, 2'd0, 1, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[16] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[17] = '{mi(1, 0, 0, 2'd2, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[18] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[19] = '{mi(1, 0, 0, 2'd0, 1, 1), mo(6'b000000, 2'd0, 0, 1, 0)};
    tbl[20] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[21] = '{mi(1, 0, 0, 2'd2, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[22] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b001111, 2'd0, 1, 0, 0)};
    tbl[23] = '{mi(0, 1, 1, 2'd2, 0, 1), mo(6'b000000, 2'd0, 0, 0, 0)};
    tbl[24] = '{mi(1, 0, 0, 2'd0, 0, 0), mo(6'b000000, 2'd0, 0, 0, 0)};

    for (int k = 0; k < 25; k++) begin
      step(tbl[k].i, $sformatf("vec%0d", k));
      check($sformatf("vec%0d/tbl", k), get_a(), tbl[k].e);
`ifdef STALL_CTRL_PERF_EN
      if (k == 23) begin
        n_cmp++;
        if (perf_a_stall !== 32'd0) begin
          n_bad++;
          $display("FAIL perf_stall_in_reset: got %0d, expected 0", perf_a_stall);
        end
      end
`endif
    end

    // Divider timeout on the 4-cycle instance, then a madd to show the flag does not block.
    step(mi(0, 0, 0, 2'd0, 0, 0), "to_rst");
    step(mi(1, 0, 0, 2'd2, 0, 0), "to_start");
    check("to_start/x", get_t(), mo(6'b001111, 2'd0, 1, 0, 0));
    for (int w = 0; w < 3; w++) begin
      step(mi(1, 0, 0, 2'd0, 0, 0), "to_wait");
      check($sformatf("to_wait%0d/x", w), get_t(), mo(6'b001111, 2'd0, 1, 0, 0));
    end
    step(mi(1, 0, 0, 2'd0, 0, 0), "to_annul");
    check("to_annul/x", get_t(), mo(6'b001111, 2'd0, 1, 1, 0));
    step(mi(1, 0, 0, 2'd0, 0, 0), "to_after");
    check("to_after/x", get_t(), mo(6'b000000, 2'd0, 0, 0, 1));
    step(mi(1, 0, 0, 2'd1, 0, 0), "to_madd1");
    check("to_madd1/x", get_t(), mo(6'b001111, 2'd0, 0, 0, 1));
    step(mi(1, 0, 0, 2'd0, 0, 0), "to_madd2");
    check("to_madd2/x", get_t(), mo(6'b000000, 2'd1, 0, 0, 1));
    step(mi(0, 0, 0, 2'd0, 0, 0), "to_clear");
    check("to_clear/x", get_t(), mo(6'b000000, 2'd0, 0, 0, 0));

    // Randomized traffic: long divider waits on both instances, occasional flush/reset.
    for (int c = 0; c < 3000; c++) begin
      in_t r;
      r.rst   = ($urandom_range(0, 63) != 0);
      r.id    = ($urandom_range(0, 3) == 0);
      r.ex    = ($urandom_range(0, 5) == 0);
      r.kind  = 2'($urandom_range(0, 3));
      r.ready = ($urandom_range(0, 11) == 0);
      r.flush = ($urandom_range(0, 15) == 0);
      step(r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
